lcd_ctrl_win: RTL and testbench
===============================

// Module: lcd_ctrl_win
// PURPOSE
//   Parametrised LCD image-window controller: loads an IMG_W x IMG_H image serially into an internal
//   buffer, keeps a WIN x WIN display window, and on command moves the window, toggles
//   horizontal/vertical mirroring, or redraws it. Each command ends with the window streamed out in
//   raster order. Sits between the host command port and the LCD pixel driver.
// PARAMETERS
//   DATA_W  8  pixel width in bits
//   IMG_W   6  image width in pixels (>= WIN)
//   IMG_H   6  image height in pixels (>= WIN)
//   WIN     3  window side in pixels (>= 1)
// PORTS
//   clk           in   1       system clock, rising edge
//   reset_n       in   1       asynchronous active-low reset
//   datain        in   DATA_W  pixel stream during LOAD, raster order, one pixel per cycle
//   cmd           in   3       0 REFLASH, 1 LOAD, 2 RIGHT, 3 LEFT, 4 UP, 5 DOWN, 6 MIRROR_H, 7 MIRROR_V
//   cmd_valid     in   1       cmd qualifier; sampled only while busy==0
//   dataout       out  DATA_W  window pixel, registered
//   output_valid  out  1       dataout valid this cycle
//   busy          out  1       command in progress; new commands ignored
// BEHAVIOUR
//   - Reset (reset_n=0, any time incl. mid-LOAD/DISP): state IDLE; busy=0, output_valid=0, dataout=0;
//     origin (x,y)=(X0,Y0); hflip=vflip=0; counters 0. Image buffer is NOT reset (contents undefined until LOAD).
//   - X0=(IMG_W-WIN+1)/2, Y0=(IMG_H-WIN+1)/2; XMAX=IMG_W-WIN, YMAX=IMG_H-WIN.
//   - FSM: IDLE, LOAD, MOVE, DISP. IDLE and busy==0 and cmd_valid==1 at edge E0 accepts cmd; busy<=1 at E0.
//     LOAD->LOAD; REFLASH->DISP; 2..7->MOVE. cmd_valid==0, or any cmd_valid while busy, has no effect.
//   - LOAD: pixel k (k=0..IMG_W*IMG_H-1) sampled from datain at edge E0+1+k into buf[k]; at the last
//     sample origin<=(X0,Y0), hflip<=vflip<=0; next state DISP.
//   - MOVE (one cycle, edge E1): RIGHT x<=min(x+1,XMAX); LEFT x<=max(x-1,0); UP y<=max(y-1,0);
//     DOWN y<=min(y+1,YMAX); MIRROR_H hflip<=~hflip; MIRROR_V vflip<=~vflip. Move at a
//     boundary leaves origin unchanged but the window is still displayed.
//   - DISP: WIN*WIN consecutive edges, output i=r*WIN+c (r,c in 0..WIN-1) registered with output_valid=1:
//     dataout=buf[(y+rr)*IMG_W + (x+cc)], rr = vflip ? WIN-1-r : r, cc = hflip ? WIN-1-c : c.
//     Address arithmetic at $clog2(IMG_W*IMG_H)+1 bits, no wrap. On the edge after the last output:
//     output_valid<=0, busy<=0, state IDLE; dataout holds its last value.
//   - Latency (from accept edge E0 to busy low): REFLASH WIN*WIN+1 cycles; MOVE cmds WIN*WIN+2;
//     LOAD IMG_W*IMG_H+WIN*WIN+1. output_valid is never high outside DISP; no gaps within DISP.
//   - A command may be accepted on the first edge where busy==0 (back-to-back, one idle cycle min).
// TESTING (defaults unless noted; image loaded as buf[k]=k)
//   1 LOAD 0..35 -> after 36 samples, 9 valid outputs 14,15,16,20,21,22,26,27,28; busy low 46 cycles after accept.
//   2 RIGHT, RIGHT -> 15,16,17,21,22,23,27,28,29 both times (x saturates at 3); LEFT x4 -> last shows 12,13,14,...
//   3 UP x3 from LOAD -> y=1: 8,9,10,...; then y=0 twice: 2,3,4,8,9,10,14,15,16.
//   4 MIRROR_H then MIRROR_V after LOAD -> 16,15,14,22,21,20,28,27,26 then 28,27,26,22,21,20,16,15,14; REFLASH repeats last.
//   5 cmd_valid=1 with DOWN while busy -> ignored (origin unchanged); reset_n low mid-DISP -> busy,output_valid 0
//     immediately; REFLASH after release shows origin (X0,Y0) window.
//   6 IMG_W=IMG_H=8, WIN=4, DATA_W=12: LOAD 0..63 -> 16 outputs from 18..21,26..29,34..37,42..45; DOWN x3 saturates y=4.

Source files
------------

// File: rtl/lcd_ctrl_win.sv
// LCD image-window controller: serially loads an image, keeps a movable and mirrorable
// WIN x WIN window over it and streams that window out in raster order after every command.
module lcd_ctrl_win #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6,
  parameter int WIN    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] datain,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              output_valid,
  output logic              busy
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX) + 1;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int XW   = $clog2(IMG_W + 1);
  localparam int YW   = $clog2(IMG_H + 1);
  localparam int CW   = $clog2(WIN + 1);
  localparam int X0   = (IMG_W - WIN + 1) / 2;
  localparam int Y0   = (IMG_H - WIN + 1) / 2;
  localparam int XMAX = IMG_W - WIN;
  localparam int YMAX = IMG_H - WIN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_MOVE = 2'd2;
  localparam logic [1:0] S_DISP = 2'd3;

  localparam logic [2:0] C_REFLASH = 3'd0;
  localparam logic [2:0] C_LOAD    = 3'd1;
  localparam logic [2:0] C_RIGHT   = 3'd2;
  localparam logic [2:0] C_LEFT    = 3'd3;
  localparam logic [2:0] C_UP      = 3'd4;
  localparam logic [2:0] C_DOWN    = 3'd5;
  localparam logic [2:0] C_MIRH    = 3'd6;
  localparam logic [2:0] C_MIRV    = 3'd7;

  logic [1:0]        state;
  logic [2:0]        cmd_r;
  logic [IW-1:0]     ld_cnt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              hflip;
  logic              vflip;
  logic [CW-1:0]     row;
  logic [CW-1:0]     col;

  logic [DATA_W-1:0] mem [0:NPIX-1];

  logic [AW-1:0]     rr;
  logic [AW-1:0]     cc;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] rd_pix;

  // Image buffer holds no reset: its contents are only meaningful after a LOAD.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      mem[ld_cnt] <= datain;
    end
  end

  // Window-relative row/column are flipped before being offset by the origin.
  always_comb begin
    rr     = vflip ? (AW'(WIN - 1) - AW'(row)) : AW'(row);
    cc     = hflip ? (AW'(WIN - 1) - AW'(col)) : AW'(col);
    addr   = (AW'(y) + rr) * AW'(IMG_W) + AW'(x) + cc;
    rd_pix = (addr < AW'(NPIX)) ? mem[addr[IW-1:0]] : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cmd_r        <= C_REFLASH;
      busy         <= 1'b0;
      output_valid <= 1'b0;
      dataout      <= '0;
      ld_cnt       <= '0;
      x            <= XW'(X0);
      y            <= YW'(Y0);
      hflip        <= 1'b0;
      vflip        <= 1'b0;
      row          <= '0;
      col          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            busy   <= 1'b1;
            cmd_r  <= cmd;
            ld_cnt <= '0;
            row    <= '0;
            col    <= '0;
            case (cmd)
              C_REFLASH: state <= S_DISP;
              C_LOAD:    state <= S_LOAD;
              default:   state <= S_MOVE;
            endcase
          end
        end

        S_LOAD: begin
          if (ld_cnt == IW'(NPIX - 1)) begin
            x     <= XW'(X0);
            y     <= YW'(Y0);
            hflip <= 1'b0;
            vflip <= 1'b0;
            state <= S_DISP;
          end else begin
            ld_cnt <= ld_cnt + IW'(1);
          end
        end

        // Moves saturate at the image edge; the window is redrawn regardless.
        S_MOVE: begin
          case (cmd_r)
            C_RIGHT: if (x != XW'(XMAX)) x <= x + XW'(1);
            C_LEFT:  if (x != '0)        x <= x - XW'(1);
            C_UP:    if (y != '0)        y <= y - YW'(1);
            C_DOWN:  if (y != YW'(YMAX)) y <= y + YW'(1);
            C_MIRH:  hflip <= ~hflip;
            C_MIRV:  vflip <= ~vflip;
            default: ;
          endcase
          state <= S_DISP;
        end

        S_DISP: begin
          if (row == CW'(WIN)) begin
            output_valid <= 1'b0;
            busy         <= 1'b0;
            row          <= '0;
            state        <= S_IDLE;
          end else begin
            dataout      <= rd_pix;
            output_valid <= 1'b1;
            if (col == CW'(WIN - 1)) begin
              col <= '0;
              row <= row + CW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_win.sv
// Bench for lcd_ctrl_win: directed command sequences plus random commands, checked against
// an array-based model of the image, window origin and mirror flags.
module tb_lcd_ctrl_win;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 6;
  localparam int IMG_H  = 6;
  localparam int WIN    = 3;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int X0     = (IMG_W - WIN + 1) / 2;
  localparam int Y0     = (IMG_H - WIN + 1) / 2;
  localparam int XMAX   = IMG_W - WIN;
  localparam int YMAX   = IMG_H - WIN;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] datain = '0;
  logic [2:0]        cmd = '0;
  logic              cmd_valid = 1'b0;
  logic [DATA_W-1:0] dataout;
  logic              output_valid;
  logic              busy;

  int n_checks = 0;
  int n_err    = 0;

  logic [DATA_W-1:0] img   [NPIX];
  logic [DATA_W-1:0] pix   [NPIX];
  int m_x, m_y;
  bit m_hf, m_vf;
  logic [DATA_W-1:0] outs  [$];
  logic [DATA_W-1:0] exp_q [$];

  lcd_ctrl_win #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
    .clk(clk), .reset_n(reset_n), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
    .dataout(dataout), .output_valid(output_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_x = X0; m_y = Y0; m_hf = 0; m_vf = 0;
  endtask

  // Expected window contents from the current model origin and flags.
  task automatic build_expect();
    int rr, cc;
    exp_q.delete();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) begin
        rr = m_vf ? WIN - 1 - r : r;
        cc = m_hf ? WIN - 1 - c : c;
        exp_q.push_back(img[(m_y + rr) * IMG_W + m_x + cc]);
      end
  endtask

  task automatic model_cmd(input int c);
    case (c)
      1: begin
        for (int k = 0; k < NPIX; k++) img[k] = pix[k];
        model_reset();
      end
      2: if (m_x < XMAX) m_x++;
      3: if (m_x > 0) m_x--;
      4: if (m_y > 0) m_y--;
      5: if (m_y < YMAX) m_y++;
      6: m_hf = !m_hf;
      7: m_vf = !m_vf;
      default: ;
    endcase
  endtask

  // Issue one command, feed pixels for LOAD, optionally keep hammering cmd_valid while busy.
  task automatic run_cmd(input int c, input bit noise);
    int lat, want_lat, limit;
    lat = -1;
    want_lat = (c == 1) ? NPIX + WIN*WIN + 1 : (c == 0) ? WIN*WIN + 1 : WIN*WIN + 2;
    limit = NPIX + WIN*WIN + 10;
    outs.delete();
    @(negedge clk);
    cmd = 3'(c); cmd_valid = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", 32'(busy), 32'd1);
    for (int t = 1; t <= limit; t++) begin
      @(negedge clk);
      if (noise) begin cmd_valid = 1'b1; cmd = 3'($urandom_range(7)); end
      else cmd_valid = 1'b0;
      datain = (c == 1 && t - 1 < NPIX) ? pix[t-1] : DATA_W'($urandom);
      @(posedge clk); #1;
      if (output_valid) outs.push_back(dataout);
      if (!busy) begin lat = t; break; end
    end
    cmd_valid = 1'b0;
    model_cmd(c);
    build_expect();
    check($sformatf("latency_cmd%0d", c), 32'(lat), 32'(want_lat));
    check("valid_low_at_end", 32'(output_valid), 32'd0);
    check("out_count", 32'(outs.size()), 32'(WIN*WIN));
    for (int i = 0; i < WIN*WIN && i < outs.size(); i++)
      check($sformatf("pix_cmd%0d_i%0d", c, i), 32'(outs[i]), 32'(exp_q[i]));
    check("dataout_hold", 32'(dataout), 32'(exp_q[WIN*WIN-1]));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(output_valid), 32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Image 0..N-1, then origin moves and mirrors.
    for (int k = 0; k < NPIX; k++) pix[k] = DATA_W'(k);
    run_cmd(1, 0);
    check("load_first_const", 32'(outs.size() > 0 ? outs[0] : 'x), 32'd14);
    check("load_last_const", 32'(outs.size() > 8 ? outs[8] : 'x), 32'd28);
    run_cmd(2, 0);
    run_cmd(2, 0);
    check("right_sat_const", 32'(outs.size() > 0 ? outs[0] : 'x), 32'd15);
    for (int i = 0; i < 4; i++) run_cmd(3, 0);
    check("left_sat_const", 32'(outs.size() > 0 ? outs[0] : 'x), 32'd12);
    run_cmd(1, 0);
    for (int i = 0; i < 3; i++) run_cmd(4, 0);
    check("up_sat_const", 32'(outs.size() > 0 ? outs[0] : 'x), 32'd2);
    run_cmd(1, 0);
    run_cmd(6, 0);
    check("mirh_const", 32'(outs.size() > 0 ? outs[0] : 'x), 32'd16);
    run_cmd(7, 0);
    check("mirv_const", 32'(outs.size() > 0 ? outs[0] : 'x), 32'd28);
    run_cmd(0, 0);
    for (int i = 0; i < 4; i++) run_cmd(5, 0);
    run_cmd(0, 1);

    // Reset in the middle of a window stream.
    run_cmd(2, 0);
    @(negedge clk);
    cmd = 3'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(output_valid), 32'd0);
    check("midrst_dataout", 32'(dataout), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    model_reset();
    run_cmd(0, 0);

    // Random command mix with random images.
    for (int n = 0; n < 60; n++) begin
      int c;
      c = $urandom_range(7);
      if (c == 1)
        for (int k = 0; k < NPIX; k++) pix[k] = DATA_W'($urandom);
      run_cmd(c, bit'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
